// File: rtl/serial_chunk_adder_pkg.sv
// Shared definitions for serial_chunk_adder: FSM state encoding and the
// WIDTH/CHUNK configuration legality check.
package serial_chunk_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    // Legal when the operand splits into a whole number of non-empty chunks.
    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/serial_chunk_adder_ripple.sv
// chunk_ripple_add: combinational CHUNK-bit ripple-carry adder built from
// CHUNK chained full-adder stages.
module chunk_ripple_add #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    always_comb begin
        logic w_c;
        w_c = ci;
        s   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ w_c;
            w_c  = (x[i] & y[i]) | (w_c & (x[i] ^ y[i]));
        end
        co = w_c;
    end

endmodule

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: WIDTH-bit add, CHUNK bits per clock, LSB chunk first.
// Define SERIAL_CHUNK_ADDER_SUB_EN to add the 'sub' port (a - b mode).
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
            $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_c_out;
    logic             r_out_valid;
    logic [CW-1:0]    r_cnt;

    logic [CHUNK-1:0] w_chunk_s;
    logic             w_chunk_co;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_b_in;
    logic             w_carry_in;
    logic             w_last;

    // Subtraction is a + ~b + 1; inverting b once at accept is the same as
    // inverting each chunk as it is consumed.
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    assign w_b_in     = sub ? ~b : b;
    assign w_carry_in = sub ? 1'b1 : c_in;
`else
    assign w_b_in     = b;
    assign w_carry_in = c_in;
`endif

    chunk_ripple_add #(.CHUNK(CHUNK)) u_ripple (
        .x  (r_a_sh[CHUNK-1:0]),
        .y  (r_b_sh[CHUNK-1:0]),
        .ci (r_carry),
        .s  (w_chunk_s),
        .co (w_chunk_co)
    );

    // Each chunk result enters at the MSB end, so after NCHUNK shifts the
    // first (LSB) chunk has arrived at bit 0.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign w_sum_next = w_chunk_s;
        end else begin : g_multi
            assign w_sum_next = {w_chunk_s, r_sum[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign w_last = (r_cnt == CW'(NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_c_out     <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= w_b_in;
                        r_carry <= w_carry_in;
                        r_cnt   <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_sum   <= w_sum_next;
                    r_a_sh  <= r_a_sh >> CHUNK;
                    r_b_sh  <= r_b_sh >> CHUNK;
                    r_carry <= w_chunk_co;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_c_out     <= w_chunk_co;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign dbg_state = r_state;

endmodule
